dish_wash_ctrl: RTL and testbench

Parametrised dish-washer cycle controller: sequences fill, wash, drain, a configurable number of rinse/drain passes and drying, with a programmable length for each phase. It adds abort handling and an optional door interlock. It drives the valve, pump, motor and heater enables of the washer datapath and reports progress to the front-panel logic.

---
 rtl/dish_wash_ctrl.sv | 153 +++++++++++++++
 tb/tb_dish_wash_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dish_wash_ctrl.sv
// Dish-washer cycle controller: fill, wash, drain, rinse/drain passes, dry, with abort drain.
// Optional door interlock pause is enabled by defining DISHWASH_DOOR_EN.
module dish_wash_ctrl #(
    parameter int FILL_CYC     = 4,
    parameter int WASH_CYC     = 5,
    parameter int DRAIN_CYC    = 3,
    parameter int RINSE_CYC    = 4,
    parameter int RINSE_PASSES = 2,
    parameter int DRY_CYC      = 6,
    parameter int CW           = 8
) (
    input  logic       clk,
    input  logic       rst,
`ifdef DISHWASH_DOOR_EN
    input  logic       door_open,
`endif
    input  logic       start,
    input  logic       abort,
    output logic       water,
    output logic       soap,
    output logic       motor,
    output logic       pump,
    output logic       heat,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        FILL        = 3'd1,
        WASH        = 3'd2,
        DRAIN       = 3'd3,
        RINSE       = 3'd4,
        DRY         = 3'd5,
        DONE        = 3'd6,
        ABORT_DRAIN = 3'd7
    } state_t;

    localparam logic [CW-1:0] FILL_LD  = CW'(FILL_CYC - 1);
    localparam logic [CW-1:0] WASH_LD  = CW'(WASH_CYC - 1);
    localparam logic [CW-1:0] DRAIN_LD = CW'(DRAIN_CYC - 1);
    localparam logic [CW-1:0] RINSE_LD = CW'(RINSE_CYC - 1);
    localparam logic [CW-1:0] DRY_LD   = CW'(DRY_CYC - 1);
    localparam logic [3:0]    PASSES   = 4'(RINSE_PASSES);

    state_t        state;
    logic [CW-1:0] timer;
    logic [3:0]    rinse_cnt;
    logic          paused;

`ifdef DISHWASH_DOOR_EN
    assign paused = door_open;
`else
    assign paused = 1'b0;
`endif

    // Timed states count down from *_CYC-1 and leave on the edge where the timer reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            rinse_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !paused) begin
                        state     <= FILL;
                        timer     <= FILL_LD;
                        rinse_cnt <= PASSES;
                    end
                end
                DONE: state <= IDLE;
                ABORT_DRAIN: begin
                    if (!paused) begin
                        if (timer == '0)
                            state <= IDLE;
                        else
                            timer <= timer - 1'b1;
                    end
                end
                default: begin
                    if (abort) begin
                        state <= ABORT_DRAIN;
                        timer <= DRAIN_LD;
                    end else if (!paused) begin
                        if (timer != '0) begin
                            timer <= timer - 1'b1;
                        end else begin
                            case (state)
                                FILL: begin
                                    state <= WASH;
                                    timer <= WASH_LD;
                                end
                                WASH, RINSE: begin
                                    state <= DRAIN;
                                    timer <= DRAIN_LD;
                                end
                                DRAIN: begin
                                    if (rinse_cnt != '0) begin
                                        state     <= RINSE;
                                        timer     <= RINSE_LD;
                                        rinse_cnt <= rinse_cnt - 1'b1;
                                    end else begin
                                        state <= DRY;
                                        timer <= DRY_LD;
                                    end
                                end
                                DRY:     state <= DONE;
                                default: state <= IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // Actuators are a decode of the state register, silenced while the door holds the cycle.
    always_comb begin
        water   = 1'b0;
        soap    = 1'b0;
        motor   = 1'b0;
        pump    = 1'b0;
        heat    = 1'b0;
        done    = 1'b0;
        aborted = 1'b0;
        case (state)
            FILL:  water = !paused;
            WASH: begin
                soap  = !paused;
                motor = !paused;
            end
            DRAIN: pump = !paused;
            RINSE: begin
                water = !paused;
                motor = !paused;
            end
            DRY:   heat = !paused;
            DONE:  done = 1'b1;
            ABORT_DRAIN: begin
                pump    = !paused;
                aborted = (timer == '0) && !paused;
            end
            default: ;
        endcase
    end

    assign busy  = (state != IDLE);
    assign phase = state;

endmodule

// File: tb/tb_dish_wash_ctrl.sv
// Scoreboard bench for dish_wash_ctrl: a default instance and a zero-rinse-pass instance
// share stimulus; expected per-cycle phase traces are queued when driven and popped at negedge.
module tb_dish_wash_ctrl;

    localparam int FILL_CYC  = 4;
    localparam int WASH_CYC  = 5;
    localparam int DRAIN_CYC = 3;
    localparam int RINSE_CYC = 4;
    localparam int DRY_CYC   = 6;

    typedef struct packed {
        logic [2:0] ph;
        logic       ab;
        logic       gate;
    } exp_t;

    typedef struct packed {
        logic r;
        logic s;
        logic a;
        logic d;
    } stim_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
`ifdef DISHWASH_DOOR_EN
    logic door_open = 1'b0;
`endif

    logic       a_water, a_soap, a_motor, a_pump, a_heat, a_busy, a_done, a_aborted;
    logic [2:0] a_phase;
    logic       b_water, b_soap, b_motor, b_pump, b_heat, b_busy, b_done, b_aborted;
    logic [2:0] b_phase;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    exp_t  sbA[$];
    exp_t  sbB[$];
    exp_t  planA[$];
    exp_t  planB[$];
    stim_t stimQ[$];
    exp_t  eA, eB;

    always #5 clk = ~clk;

    dish_wash_ctrl dut_a (
        .clk(clk), .rst(rst),
`ifdef DISHWASH_DOOR_EN
        .door_open(door_open),
`endif
        .start(start), .abort(abort),
        .water(a_water), .soap(a_soap), .motor(a_motor), .pump(a_pump), .heat(a_heat),
        .busy(a_busy), .done(a_done), .aborted(a_aborted), .phase(a_phase)
    );

    dish_wash_ctrl #(.RINSE_PASSES(0)) dut_b (
        .clk(clk), .rst(rst),
`ifdef DISHWASH_DOOR_EN
        .door_open(door_open),
`endif
        .start(start), .abort(abort),
        .water(b_water), .soap(b_soap), .motor(b_motor), .pump(b_pump), .heat(b_heat),
        .busy(b_busy), .done(b_done), .aborted(b_aborted), .phase(b_phase)
    );

    task automatic checkOutput(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic compareDut(input string nm, input logic [2:0] ph,
                              input logic w, input logic s, input logic m, input logic p,
                              input logic h, input logic b, input logic d, input logic ab,
                              input exp_t e);
        logic on;
        on = !e.gate;
        checkOutput($sformatf("%s.phase@%0d", nm, cyc), ph, e.ph);
        checkOutput($sformatf("%s.water@%0d", nm, cyc), {2'b00, w},
                    {2'b00, on && (e.ph == 3'd1 || e.ph == 3'd4)});
        checkOutput($sformatf("%s.soap@%0d", nm, cyc), {2'b00, s}, {2'b00, on && e.ph == 3'd2});
        checkOutput($sformatf("%s.motor@%0d", nm, cyc), {2'b00, m},
                    {2'b00, on && (e.ph == 3'd2 || e.ph == 3'd4)});
        checkOutput($sformatf("%s.pump@%0d", nm, cyc), {2'b00, p},
                    {2'b00, on && (e.ph == 3'd3 || e.ph == 3'd7)});
        checkOutput($sformatf("%s.heat@%0d", nm, cyc), {2'b00, h}, {2'b00, on && e.ph == 3'd5});
        checkOutput($sformatf("%s.busy@%0d", nm, cyc), {2'b00, b}, {2'b00, e.ph != 3'd0});
        checkOutput($sformatf("%s.done@%0d", nm, cyc), {2'b00, d}, {2'b00, e.ph == 3'd6});
        checkOutput($sformatf("%s.aborted@%0d", nm, cyc), {2'b00, ab}, {2'b00, e.ab});
    endtask

    // Each queued entry describes the outputs expected after the edge that followed its push.
    always @(negedge clk) begin
        cyc++;
        if (sbA.size() != 0) begin
            eA = sbA.pop_front();
            compareDut("A", a_phase, a_water, a_soap, a_motor, a_pump, a_heat,
                       a_busy, a_done, a_aborted, eA);
        end
        if (sbB.size() != 0) begin
            eB = sbB.pop_front();
            compareDut("B", b_phase, b_water, b_soap, b_motor, b_pump, b_heat,
                       b_busy, b_done, b_aborted, eB);
        end
    end

    function automatic exp_t mk(input logic [2:0] ph, input logic ab, input logic g);
        exp_t e;
        e.ph   = ph;
        e.ab   = ab;
        e.gate = g;
        return e;
    endfunction

    task automatic applyStimulus(input stim_t st, input exp_t ea, input exp_t eb);
        @(negedge clk);
        #1;
        rst   = st.r;
        start = st.s;
        abort = st.a;
`ifdef DISHWASH_DOOR_EN
        door_open = st.d;
`endif
        sbA.push_back(ea);
        sbB.push_back(eb);
    endtask

    task automatic stimAdd(input logic r, input logic s, input logic a, input logic d, input int n);
        stim_t st;
        st.r = r;
        st.s = s;
        st.a = a;
        st.d = d;
        for (int i = 0; i < n; i++) stimQ.push_back(st);
    endtask

    task automatic planPush(input int which, input logic [2:0] ph, input logic ab, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) planA.push_back(mk(ph, ab, 1'b0));
            else            planB.push_back(mk(ph, ab, 1'b0));
        end
    endtask

    // Expected phase trace of one normal cycle, one entry per edge starting at the start edge.
    task automatic planRun(input int which, input int passes, input int maxItems,
                           input int doorAt, input int doorLen);
        exp_t q[$];
        for (int i = 0; i < FILL_CYC + doorLen; i++)
            q.push_back(mk(3'd1, 1'b0, (i >= doorAt) && (i < doorAt + doorLen)));
        for (int i = 0; i < WASH_CYC; i++) q.push_back(mk(3'd2, 1'b0, 1'b0));
        for (int i = 0; i < DRAIN_CYC; i++) q.push_back(mk(3'd3, 1'b0, 1'b0));
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < RINSE_CYC; i++) q.push_back(mk(3'd4, 1'b0, 1'b0));
            for (int i = 0; i < DRAIN_CYC; i++) q.push_back(mk(3'd3, 1'b0, 1'b0));
        end
        for (int i = 0; i < DRY_CYC; i++) q.push_back(mk(3'd5, 1'b0, 1'b0));
        q.push_back(mk(3'd6, 1'b0, 1'b0));
        for (int i = 0; i < q.size() && i < maxItems; i++) begin
            if (which == 0) planA.push_back(q[i]);
            else            planB.push_back(q[i]);
        end
    endtask

    task automatic playScenario(input string name);
        while (planA.size() < stimQ.size()) planA.push_back(mk(3'd0, 1'b0, 1'b0));
        while (planB.size() < stimQ.size()) planB.push_back(mk(3'd0, 1'b0, 1'b0));
        $display("[TB] scenario %s, %0d cycles", name, stimQ.size());
        for (int i = 0; i < stimQ.size(); i++) applyStimulus(stimQ[i], planA[i], planB[i]);
        stimQ.delete();
        planA.delete();
        planB.delete();
    endtask

    initial begin
        stimAdd(1'b1, 1'b0, 1'b0, 1'b0, 3);
        playScenario("reset");

        stimAdd(1'b0, 1'b1, 1'b0, 1'b0, 1);
        stimAdd(1'b0, 1'b0, 1'b0, 1'b0, 36);
        planRun(0, 2, 999, 0, 0);
        planRun(1, 0, 999, 0, 0);
        playScenario("normal");

        // Abort sampled at the end of the third WASH cycle.
        stimAdd(1'b0, 1'b1, 1'b0, 1'b0, 1);
        stimAdd(1'b0, 1'b0, 1'b0, 1'b0, 6);
        stimAdd(1'b0, 1'b0, 1'b1, 1'b0, 1);
        stimAdd(1'b0, 1'b0, 1'b0, 1'b0, 5);
        for (int w = 0; w < 2; w++) begin
            planRun(w, 2 - 2 * w, 7, 0, 0);
            planPush(w, 3'd7, 1'b0, 2);
            planPush(w, 3'd7, 1'b1, 1);
        end
        playScenario("abort_wash");

        // Abort on the FILL expiry edge wins, and stays held through ABORT_DRAIN and IDLE.
        stimAdd(1'b0, 1'b1, 1'b0, 1'b0, 1);
        stimAdd(1'b0, 1'b0, 1'b0, 1'b0, 3);
        stimAdd(1'b0, 1'b0, 1'b1, 1'b0, 6);
        stimAdd(1'b0, 1'b0, 1'b0, 1'b0, 2);
        for (int w = 0; w < 2; w++) begin
            planRun(w, 2 - 2 * w, 4, 0, 0);
            planPush(w, 3'd7, 1'b0, 2);
            planPush(w, 3'd7, 1'b1, 1);
        end
        playScenario("abort_priority");

        // start+abort together in IDLE, then start held through completion.
        stimAdd(1'b0, 1'b1, 1'b1, 1'b0, 1);
        stimAdd(1'b0, 1'b1, 1'b0, 1'b0, 34);
        stimAdd(1'b0, 1'b0, 1'b0, 1'b0, 35);
        for (int w = 0; w < 2; w++) begin
            planRun(w, 2 - 2 * w, 999, 0, 0);
            planPush(w, 3'd0, 1'b0, 1);
            planRun(w, 2 - 2 * w, 999, 0, 0);
        end
        playScenario("start_held");

        stimAdd(1'b0, 1'b1, 1'b0, 1'b0, 1);
        stimAdd(1'b0, 1'b0, 1'b0, 1'b0, 27);
        stimAdd(1'b1, 1'b0, 1'b0, 1'b0, 1);
        stimAdd(1'b0, 1'b0, 1'b0, 1'b0, 6);
        planRun(0, 2, 28, 0, 0);
        planRun(1, 0, 999, 0, 0);
        playScenario("reset_in_dry");

`ifdef DISHWASH_DOOR_EN
        stimAdd(1'b0, 1'b1, 1'b0, 1'b0, 1);
        stimAdd(1'b0, 1'b0, 1'b0, 1'b0, 1);
        stimAdd(1'b0, 1'b0, 1'b0, 1'b1, 5);
        stimAdd(1'b0, 1'b0, 1'b0, 1'b0, 40);
        planRun(0, 2, 999, 2, 5);
        planRun(1, 0, 999, 2, 5);
        playScenario("door_pause");
`endif

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
